aibcr3_red_shift_bsr_n: RTL and testbench
=========================================

# aibcr3_red_shift_bsr_n

Parametrised redundancy-shift and boundary-scan controller for an N-lane AIB IO column with one spare lane. It replaces the per-buffer static shift_en/prev_io_shift_en chaining with a registered repair configuration, loaded at run time. Each repair change runs a sequenced analog-reset hold so lanes never switch while the pad drivers are active. It also carries an N-cell JTAG boundary-scan chain with capture, shift and update.

## Interface
Parameters:
- NLANE, 8, number of functional lanes (≥2); spare lane is lane NLANE.
- RST_HOLD, 4, cycles anlg_rstb_out is held low before shift_en changes (≥1).
- SETTLE, 8, cycles after the shift_en change before anlg_rstb_out is released (≥1).
- IDXW (localparam), $clog2(NLANE), repair index width.

Ports:
- jtag_clkdr_in  in  1  sole clock, rising edge.
- jtag_rstb  in  1  synchronous, active-low reset.
- anlg_rstb  in  1  adapter analog reset request, active-low.
- red_load  in  1  single-cycle request to apply red_en/red_idx.
- red_en  in  1  1 = repair active, 0 = no lane shifted.
- red_idx  in  IDXW  faulty lane index.
- shift_en  out  NLANE  per-lane shift select; lanes ≥ active index shift toward the spare.
- anlg_rstb_out  out  1  gated analog reset to the IO buffers.
- red_busy  out  1  repair sequence in progress.
- red_err  out  1  one-cycle pulse: red_load rejected.
- jtag_tx_scan_in  in  1  scan data in.
- jtag_tx_scanen_in  in  1  shift enable.
- jtag_capture  in  1  capture rx_dat into the chain.
- jtag_update  in  1  transfer the chain to tx_bsr.
- rx_dat  in  NLANE  per-lane receive data to capture.
- tx_bsr  out  NLANE  update-register outputs.
- jtag_rx_scan_out  out  1  scan data out, equal to chain cell NLANE-1.

## Operation
- All outputs reset to 0 while jtag_rstb=0. Reset has priority over every other input, including mid-sequence: the FSM returns to IDLE and the repair config is cleared.
- The repair config register {cur_en, cur_idx} drives shift_en[i] = cur_en & (i ≥ cur_idx).
- FSM states: IDLE, HOLD, SETTLE.
- IDLE:
  - anlg_rstb_out <= anlg_rstb.
  - red_load=1 with red_en=1 and red_idx ≥ NLANE: red_err pulses, no state change.
  - red_load=1 with {red_en,red_idx} equal to the current config: no-op. When cur_en=0 and red_en=0, red_idx is don't-care.
  - Any other red_load: latch the pending config, go to HOLD, counter cleared.
- HOLD: anlg_rstb_out=0, red_busy=1. After RST_HOLD cycles, commit the pending config to shift_en and go to SETTLE.
- SETTLE: anlg_rstb_out=0, red_busy=1. After SETTLE cycles, go to IDLE.
- red_load while red_busy=1 is rejected with a red_err pulse; the in-flight sequence continues unchanged.
- Scan chain is an NLANE-bit shift register sr, with priority shift > capture > update when inputs coincide:
  - shift: sr[0]<=jtag_tx_scan_in, sr[i]<=sr[i-1].
  - capture: sr<=rx_dat.
  - update: tx_bsr<=sr.
- The scan chain is independent of the FSM and of shift_en.

## Timing
- Let edge k sample an accepted red_load.
- After edge k: red_busy=1, anlg_rstb_out=0.
- After edge k+RST_HOLD: shift_en takes the new value.
- After edge k+RST_HOLD+SETTLE: red_busy=0. anlg_rstb_out = anlg_rstb as sampled at that edge, and follows anlg_rstb with 1-cycle latency thereafter.
- red_err is asserted the cycle after the rejected red_load and lasts exactly 1 cycle.
- The scan chain has 1-cycle latency on each operation. jtag_rx_scan_out shows a bit shifted in at edge j after edge j+NLANE-1.

## Test plan
- Reset then release, with NLANE=8, RST_HOLD=4, SETTLE=8, anlg_rstb=1:
  - All outputs are 0 at reset.
  - Next cycle anlg_rstb_out=1, shift_en=8'h00.
- red_load with red_en=1, red_idx=3:
  - anlg_rstb_out low 12 cycles.
  - shift_en=8'hF8 exactly 4 cycles after load.
  - red_busy high 12 cycles, then release.
- During that sequence, red_load with red_idx=5:
  - red_err pulse 1 cycle.
  - shift_en stays 8'hF8; sequence length unchanged.
- Error and no-op loads:
  - red_idx=9 is out of range for IDXW=3; use NLANE=6, red_idx=7 → red_err, config unchanged.
  - Reload identical config → no busy, no reset dip.
- Assert jtag_rstb=0 at cycle 2 of HOLD: next cycle shift_en=0, red_busy=0, anlg_rstb_out=0, FSM in IDLE.
- Scan sequence:
  - Capture rx_dat=8'hA5, then shift 8 cycles with scan_in=1 → jtag_rx_scan_out emits 1,0,1,0,0,1,0,1.
  - Update → tx_bsr=8'hFF.
  - Capture and shift asserted together → shift wins.

Source files
------------

// File: rtl/aibcr3_red_shift_bsr_n_if.sv
// rtl/aibcr3_red_shift_bsr_n_if.sv - repair-request handshake bundle
// Purpose: carries a run-time repair request into the redundancy controller
//   and returns its busy/reject status.
// Signals:
//   red_load  master->slave  single-cycle request to apply red_en/red_idx
//   red_en    master->slave  1 = repair active, 0 = no lane shifted
//   red_idx   master->slave  faulty lane index
//   red_busy  slave->master  repair sequence in progress
//   red_err   slave->master  one-cycle pulse, request rejected
interface aibcr3_red_shift_bsr_n_if #(
  parameter int NLANE = 8
);
  localparam int IDXW = $clog2(NLANE);

  logic            red_load;
  logic            red_en;
  logic [IDXW-1:0] red_idx;
  logic            red_busy;
  logic            red_err;

  modport master (output red_load, red_en, red_idx, input red_busy, red_err);
  modport slave  (input red_load, red_en, red_idx, output red_busy, red_err);
endinterface

// File: rtl/aibcr3_red_shift_bsr_n.sv
// rtl/aibcr3_red_shift_bsr_n.sv - AIB column redundancy shift and boundary-scan controller
// Purpose: holds the registered lane-repair configuration, sequences each
//   repair change under an analog-reset hold, and implements an NLANE-cell
//   boundary-scan chain with capture/shift/update.
// Ports:
//   jtag_clkdr_in     in   sole clock, rising edge
//   jtag_rstb         in   synchronous active-low reset
//   anlg_rstb         in   adapter analog reset request, active-low
//   red_if            slave repair request (red_load/red_en/red_idx) and status (red_busy/red_err)
//   shift_en          out  per-lane shift select toward the spare lane
//   anlg_rstb_out     out  gated analog reset to the IO buffers
//   jtag_tx_scan_in   in   scan data in
//   jtag_tx_scanen_in in   shift enable
//   jtag_capture      in   capture rx_dat into the chain
//   jtag_update       in   transfer the chain to tx_bsr
//   rx_dat            in   per-lane receive data
//   tx_bsr            out  update-register outputs
//   jtag_rx_scan_out  out  scan data out (last chain cell)
module aibcr3_red_shift_bsr_n #(
  parameter int NLANE    = 8,
  parameter int RST_HOLD = 4,
  parameter int SETTLE   = 8
) (
  input  logic                       jtag_clkdr_in,
  input  logic                       jtag_rstb,
  input  logic                       anlg_rstb,
  aibcr3_red_shift_bsr_n_if.slave    red_if,
  output logic [NLANE-1:0]           shift_en,
  output logic                       anlg_rstb_out,
  input  logic                       jtag_tx_scan_in,
  input  logic                       jtag_tx_scanen_in,
  input  logic                       jtag_capture,
  input  logic                       jtag_update,
  input  logic [NLANE-1:0]           rx_dat,
  output logic [NLANE-1:0]           tx_bsr,
  output logic                       jtag_rx_scan_out
);
  localparam int IDXW = $clog2(NLANE);
  localparam int CMAX = (RST_HOLD > SETTLE) ? RST_HOLD : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SETTLE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_cur_en;
  logic [IDXW-1:0] r_cur_idx;
  logic            r_pend_en;
  logic [IDXW-1:0] r_pend_idx;
  logic            r_err;
  logic            r_rstb_out;
  logic [NLANE-1:0] r_sr;
  logic [NLANE-1:0] r_tx_bsr;

  logic w_accept;
  logic w_commit;
  logic w_reject;
  logic w_idx_oob;
  logic w_same;

  assign w_idx_oob = (int'(red_if.red_idx) >= NLANE);
  // With repair disabled on both sides the index carries no meaning.
  assign w_same = (red_if.red_en == r_cur_en) &&
                  (!red_if.red_en || (red_if.red_idx == r_cur_idx));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (red_if.red_load) begin
          if (red_if.red_en && w_idx_oob) begin
            w_reject = 1'b1;
          end else if (!w_same) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        w_reject = red_if.red_load;
        if (r_cnt == HOLD_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_reject = red_if.red_load;
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge jtag_clkdr_in) begin
    if (!jtag_rstb) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cur_en   <= 1'b0;
      r_cur_idx  <= '0;
      r_pend_en  <= 1'b0;
      r_pend_idx <= '0;
      r_err      <= 1'b0;
      r_rstb_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Counter restarts on every state change so each phase counts from zero.
      r_cnt   <= ((r_state == ST_IDLE) || (w_state_nxt != r_state)) ? '0 : r_cnt + CW'(1);
      r_err   <= w_reject;
      // Pads only see the adapter reset once the sequence has fully returned to idle.
      r_rstb_out <= (w_state_nxt == ST_IDLE) ? anlg_rstb : 1'b0;
      if (w_accept) begin
        r_pend_en  <= red_if.red_en;
        r_pend_idx <= red_if.red_idx;
      end
      if (w_commit) begin
        r_cur_en  <= r_pend_en;
        r_cur_idx <= r_pend_idx;
      end
    end
  end

  always_comb begin
    shift_en = '0;
    for (int i = 0; i < NLANE; i++) begin
      shift_en[i] = r_cur_en && (i >= int'(r_cur_idx));
    end
  end

  assign anlg_rstb_out   = r_rstb_out;
  assign red_if.red_busy = (r_state != ST_IDLE);
  assign red_if.red_err  = r_err;

  // Boundary-scan chain: shift beats capture beats update.
  always_ff @(posedge jtag_clkdr_in) begin
    if (!jtag_rstb) begin
      r_sr     <= '0;
      r_tx_bsr <= '0;
    end else if (jtag_tx_scanen_in) begin
      r_sr <= {r_sr[NLANE-2:0], jtag_tx_scan_in};
    end else if (jtag_capture) begin
      r_sr <= rx_dat;
    end else if (jtag_update) begin
      r_tx_bsr <= r_sr;
    end
  end

  assign tx_bsr           = r_tx_bsr;
  assign jtag_rx_scan_out = r_sr[NLANE-1];
endmodule

// File: tb/tb_aibcr3_red_shift_bsr_n.sv
// tb/tb_aibcr3_red_shift_bsr_n.sv - scoreboard bench for the redundancy/boundary-scan controller
module tb_aibcr3_red_shift_bsr_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb, arstb, scan_in, scanen, capture, update;
  logic [7:0] rx_dat, shift_en, tx_bsr;
  logic       rstb_out, scan_out;
  logic [5:0] rx6, shift6, tx6;
  logic       rstb_out6, scan_out6;

  aibcr3_red_shift_bsr_n_if #(.NLANE(8)) rif();
  aibcr3_red_shift_bsr_n_if #(.NLANE(6)) rif6();

  aibcr3_red_shift_bsr_n #(.NLANE(8), .RST_HOLD(4), .SETTLE(8)) dut (
    .jtag_clkdr_in(clk), .jtag_rstb(rstb), .anlg_rstb(arstb), .red_if(rif),
    .shift_en(shift_en), .anlg_rstb_out(rstb_out),
    .jtag_tx_scan_in(scan_in), .jtag_tx_scanen_in(scanen),
    .jtag_capture(capture), .jtag_update(update), .rx_dat(rx_dat),
    .tx_bsr(tx_bsr), .jtag_rx_scan_out(scan_out));

  aibcr3_red_shift_bsr_n #(.NLANE(6), .RST_HOLD(4), .SETTLE(8)) dut6 (
    .jtag_clkdr_in(clk), .jtag_rstb(rstb), .anlg_rstb(arstb), .red_if(rif6),
    .shift_en(shift6), .anlg_rstb_out(rstb_out6),
    .jtag_tx_scan_in(scan_in), .jtag_tx_scanen_in(scanen),
    .jtag_capture(capture), .jtag_update(update), .rx_dat(rx6),
    .tx_bsr(tx6), .jtag_rx_scan_out(scan_out6));

  typedef enum {S_SHIFT, S_RSTO, S_BUSY, S_ERR, S_TX, S_SOUT,
                S_SHIFT6, S_RSTO6, S_BUSY6, S_ERR6, S_TX6, S_SOUT6} sel_e;
  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect signal s to equal v after edge (current edge count + ofs).
  task automatic expect_at(input int ofs, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + ofs;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input sel_e s);
    case (s)
      S_SHIFT:  return {24'h0, shift_en};
      S_RSTO:   return {31'h0, rstb_out};
      S_BUSY:   return {31'h0, rif.red_busy};
      S_ERR:    return {31'h0, rif.red_err};
      S_TX:     return {24'h0, tx_bsr};
      S_SOUT:   return {31'h0, scan_out};
      S_SHIFT6: return {26'h0, shift6};
      S_RSTO6:  return {31'h0, rstb_out6};
      S_BUSY6:  return {31'h0, rif6.red_busy};
      S_ERR6:   return {31'h0, rif6.red_err};
      S_TX6:    return {26'h0, tx6};
      S_SOUT6:  return {31'h0, scan_out6};
      default:  return 32'h0;
    endcase
  endfunction

  // Monitor: compares every expectation that falls due on this cycle.
  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        n_chk++;
        if (actual(sb[i].sel) !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %0h expected %0h",
                   sb[i].sel.name(), cyc, actual(sb[i].sel), sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s cyc %0d: expectation never sampled", sb[i].sel.name(), sb[i].cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  initial begin
    logic [7:0] cap;
    cap = 8'hA5;
    rstb = 1'b0; arstb = 1'b1; scan_in = 1'b0; scanen = 1'b0;
    capture = 1'b0; update = 1'b0; rx_dat = 8'h00; rx6 = 6'h00;
    rif.red_load = 1'b0;  rif.red_en = 1'b0;  rif.red_idx = '0;
    rif6.red_load = 1'b0; rif6.red_en = 1'b0; rif6.red_idx = '0;
    tick(); tick();

    // Reset state
    expect_at(0, S_SHIFT, 0); expect_at(0, S_RSTO, 0); expect_at(0, S_BUSY, 0);
    expect_at(0, S_ERR, 0);   expect_at(0, S_TX, 0);   expect_at(0, S_SOUT, 0);
    expect_at(0, S_SHIFT6, 0); expect_at(0, S_RSTO6, 0); expect_at(0, S_BUSY6, 0);
    expect_at(0, S_ERR6, 0);  expect_at(0, S_TX6, 0);  expect_at(0, S_SOUT6, 0);
    rstb = 1'b1;
    expect_at(1, S_RSTO, 1); expect_at(1, S_SHIFT, 0); expect_at(1, S_RSTO6, 1);
    tick();

    // NLANE=6: repair at the last functional lane, then an out-of-range index
    rif6.red_load = 1'b1; rif6.red_en = 1'b1; rif6.red_idx = 3'd5;
    expect_at(1, S_BUSY6, 1); expect_at(4, S_SHIFT6, 6'h00); expect_at(5, S_SHIFT6, 6'h20);
    expect_at(12, S_BUSY6, 1); expect_at(13, S_BUSY6, 0); expect_at(13, S_RSTO6, 1);
    tick(); rif6.red_load = 1'b0;
    repeat (13) tick();
    rif6.red_load = 1'b1; rif6.red_en = 1'b1; rif6.red_idx = 3'd7;
    expect_at(1, S_ERR6, 1); expect_at(2, S_ERR6, 0); expect_at(1, S_BUSY6, 0);
    expect_at(1, S_RSTO6, 1); expect_at(1, S_SHIFT6, 6'h20); expect_at(6, S_SHIFT6, 6'h20);
    tick(); rif6.red_load = 1'b0;
    repeat (3) tick();

    // Repair lane 3: 4-cycle hold, 8-cycle settle
    rif.red_load = 1'b1; rif.red_en = 1'b1; rif.red_idx = 3'd3;
    for (int j = 1; j <= 12; j++) begin
      expect_at(j, S_BUSY, 1);
      expect_at(j, S_RSTO, 0);
    end
    expect_at(13, S_BUSY, 0); expect_at(13, S_RSTO, 1);
    expect_at(4, S_SHIFT, 8'h00); expect_at(5, S_SHIFT, 8'hF8); expect_at(13, S_SHIFT, 8'hF8);
    expect_at(1, S_ERR, 0);
    tick(); rif.red_load = 1'b0;
    tick(); tick();
    // Load during the sequence is rejected
    rif.red_load = 1'b1; rif.red_idx = 3'd5;
    expect_at(1, S_ERR, 1); expect_at(2, S_ERR, 0);
    tick(); rif.red_load = 1'b0;
    repeat (12) tick();

    // Identical config is a no-op
    rif.red_load = 1'b1; rif.red_en = 1'b1; rif.red_idx = 3'd3;
    expect_at(1, S_BUSY, 0); expect_at(1, S_RSTO, 1); expect_at(2, S_RSTO, 1);
    expect_at(1, S_ERR, 0); expect_at(5, S_SHIFT, 8'hF8);
    tick(); rif.red_load = 1'b0;
    repeat (5) tick();

    // Reset during the second HOLD cycle
    rif.red_load = 1'b1; rif.red_en = 1'b1; rif.red_idx = 3'd6;
    tick(); rif.red_load = 1'b0;
    expect_at(0, S_BUSY, 1); expect_at(0, S_SHIFT, 8'hF8);
    rstb = 1'b0;
    expect_at(1, S_SHIFT, 0); expect_at(1, S_BUSY, 0); expect_at(1, S_RSTO, 0); expect_at(1, S_ERR, 0);
    tick(); rstb = 1'b1;
    expect_at(1, S_RSTO, 1); expect_at(1, S_BUSY, 0); expect_at(5, S_SHIFT, 0); expect_at(5, S_BUSY, 0);
    repeat (6) tick();

    // anlg_rstb follows with one cycle of latency in idle
    arstb = 1'b0; expect_at(1, S_RSTO, 0);
    tick(); arstb = 1'b1; expect_at(1, S_RSTO, 1);
    tick();

    // Capture A5 then shift ones through
    rx_dat = cap; capture = 1'b1;
    for (int j = 0; j < 8; j++) expect_at(1 + j, S_SOUT, {31'h0, cap[7-j]});
    expect_at(9, S_SOUT, 1); expect_at(9, S_TX, 0);
    tick(); capture = 1'b0; scanen = 1'b1; scan_in = 1'b1;
    repeat (8) tick();
    scanen = 1'b0; update = 1'b1; expect_at(1, S_TX, 8'hFF);
    tick(); update = 1'b0;

    // Capture with shift: shift wins
    rx_dat = 8'h00; capture = 1'b1; scanen = 1'b1; scan_in = 1'b0;
    expect_at(1, S_SOUT, 1);
    tick(); capture = 1'b0; scanen = 1'b0; update = 1'b1;
    expect_at(1, S_TX, 8'hFE);
    tick(); update = 1'b0;
    repeat (3) tick();

    foreach (sb[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s cyc %0d: expectation left unchecked", sb[i].sel.name(), sb[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
